// File: rtl/mem_fold_scheduler_pkg.sv
// mem_fold_pkg: shared types and defaults for the folded-memory scheduler.
//   state_e    controller phase for the current job
//   chan_t     channel index (two channels)
//   pick_chan  arbiter: the lone requester, or the one not served last
package mem_fold_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {IDLE, FILL, INC, DRAIN} state_e;

  typedef logic chan_t;

  // Contention alternates so neither channel can starve the other.
  function automatic chan_t pick_chan(input logic [1:0] req, input chan_t last_srv);
    if (req == 2'b11) return ~last_srv;
    return req[1];
  endfunction

endpackage

// File: rtl/mem_fold_scheduler_if.sv
// mem_fold_scheduler_if: channel-side bus of the scheduler.
//   master: front-end side (drives req, fill data, drain ready)
//   slave : scheduler side (drives grant, handshakes, drain data, done, busy)
interface mem_fold_scheduler_if #(parameter int WIDTH = 8);

  logic [1:0]       req;
  logic [1:0]       grant;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_chan;
  logic [1:0]       done;
  logic             busy;

  modport master (
    output req, in_valid, in_data, out_ready,
    input  grant, in_ready, out_valid, out_data, out_last, out_chan, done, busy
  );

  modport slave (
    input  req, in_valid, in_data, out_ready,
    output grant, in_ready, out_valid, out_data, out_last, out_chan, done, busy
  );

endinterface

// File: rtl/mem_fold_scheduler_fold_mem.sv
// fold_mem: DEPTH x WIDTH register array shared by both channels.
//   clk      write clock
//   we_i     write enable (synchronous)
//   addr_i   single address for both write and read
//   wdata_i  write data
//   rdata_o  asynchronous read of mem[addr_i]
// Contents are deliberately not reset; they persist across jobs.
module fold_mem
  import mem_fold_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/mem_fold_scheduler.sv
// mem_fold_scheduler: time-multiplexes one folded memory between two channels.
// Each granted job runs FILL (write DEPTH words from the channel), INC (add 1
// to every word in place), DRAIN (stream the words back out).
//   clk, rst  clock, asynchronous active-high reset
//   bus       slave side of mem_fold_scheduler_if (req/grant, fill, drain,
//             done pulse, busy)
module mem_fold_scheduler
  import mem_fold_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  mem_fold_scheduler_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        done_q, done_d;
  chan_t             last_srv_q, last_srv_d;

  logic              we;
  logic [WIDTH-1:0]  wdata, rdata;
  chan_t             owner;
  logic              addr_end;

  assign owner    = grant_q[1];
  assign addr_end = (addr_q == ADDR_W'(DEPTH - 1));

  fold_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .we_i    (we),
    .addr_i  (addr_q),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      last_srv_q <= 1'b1;   // channel 0 wins the first contention
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      last_srv_q <= last_srv_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    grant_d    = grant_q;
    done_d     = '0;
    last_srv_d = last_srv_q;
    we         = 1'b0;
    wdata      = bus.in_data;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_d = pick_chan(bus.req, last_srv_q) ? 2'b10 : 2'b01;
          addr_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (bus.in_valid) begin
          we     = 1'b1;
          addr_d = addr_q + 1'b1;
          if (addr_end) begin
            addr_d  = '0;
            state_d = INC;
          end
        end
      end
      INC: begin
        // read-modify-write on the same address in one cycle
        we     = 1'b1;
        wdata  = rdata + 1'b1;
        addr_d = addr_q + 1'b1;
        if (addr_end) begin
          addr_d  = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          addr_d = addr_q + 1'b1;
          if (addr_end) begin
            addr_d     = '0;
            done_d     = grant_q;
            last_srv_d = owner;
            grant_d    = '0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_data  = (state_q == DRAIN) ? rdata : '0;
  assign bus.out_last  = (state_q == DRAIN) && addr_end;
  assign bus.out_chan  = (state_q == DRAIN) && owner;

endmodule
